// File: rtl/dcache_miss_ctrl_if.sv
// Signal bundle between the dcache miss/flush controller, the cache arrays and data memory.
// master = controller side, slave = cache arrays / memory side.
interface dcache_miss_ctrl_if #(
  parameter int TAG_W = 26,
  parameter int IDX_W = 3
);
  // access logic request side
  logic              miss;
  logic              victim_way;
  logic              halt;
  logic [31:0]       req_addr;
  // cache array read port
  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data0;
  logic [31:0]       rd_data1;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_way;
  // memory port
  logic              dwait;
  logic [31:0]       dload;
  logic              dREN;
  logic              dWEN;
  logic [31:0]       daddr;
  logic [31:0]       dstore;
  // cache array update port
  logic              fill_wen;
  logic              fill_offset;
  logic [31:0]       fill_data;
  logic              line_commit;
  logic [TAG_W-1:0]  fill_tag;
  logic              line_clean;
  // status
  logic              busy;
  logic              flushed;

  modport master (
    input  miss, victim_way, halt, req_addr,
    input  rd_valid, rd_dirty, rd_tag, rd_data0, rd_data1,
    input  dwait, dload,
    output rd_idx, rd_way,
    output dREN, dWEN, daddr, dstore,
    output fill_wen, fill_offset, fill_data, line_commit, fill_tag, line_clean,
    output busy, flushed
  );

  modport slave (
    output miss, victim_way, halt, req_addr,
    output rd_valid, rd_dirty, rd_tag, rd_data0, rd_data1,
    output dwait, dload,
    input  rd_idx, rd_way,
    input  dREN, dWEN, daddr, dstore,
    input  fill_wen, fill_offset, fill_data, line_commit, fill_tag, line_clean,
    input  busy, flushed
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Dcache miss/flush controller: writes back a dirty victim, fills the 2-word block and commits it;
// on halt, walks every line and writes back all valid+dirty lines before raising flushed.
module dcache_miss_ctrl #(
  parameter int TAG_W = 26,
  parameter int IDX_W = 3
) (
  input logic                CLK,
  input logic                nRST,
  dcache_miss_ctrl_if.master bus
);

  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, FILL0, FILL1, FL_CHK, FL_WB0, FL_WB1, FL_NEXT, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               way_q, way_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [IDX_W-1:0]   cur_idx;
  logic               cur_way;
  logic               off;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      way_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    way_d   = way_q;
    tag_d   = tag_q;
    unique case (state_q)
      IDLE: begin
        if (bus.halt) begin
          state_d = FL_CHK;
          cnt_d   = '0;
        end else if (bus.miss) begin
          idx_d   = bus.req_addr[IDX_W+2:3];
          tag_d   = bus.req_addr[31:IDX_W+3];
          way_d   = bus.victim_way;
          state_d = (bus.rd_valid && bus.rd_dirty) ? WB0 : FILL0;
        end
      end
      WB0:     if (!bus.dwait) state_d = WB1;
      WB1:     if (!bus.dwait) state_d = FILL0;
      FILL0:   if (!bus.dwait) state_d = FILL1;
      FILL1:   if (!bus.dwait) state_d = IDLE;
      FL_CHK:  state_d = (bus.rd_valid && bus.rd_dirty) ? FL_WB0 : FL_NEXT;
      FL_WB0:  if (!bus.dwait) state_d = FL_WB1;
      FL_WB1:  if (!bus.dwait) state_d = FL_NEXT;
      FL_NEXT: begin
        if (cnt_q == '1) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FL_CHK;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the arrays are probed at the incoming request so the victim check is ready on accept.
  always_comb begin
    cur_idx         = idx_q;
    cur_way         = way_q;
    off             = 1'b0;
    bus.rd_idx      = '0;
    bus.rd_way      = 1'b0;
    bus.dREN        = 1'b0;
    bus.dWEN        = 1'b0;
    bus.daddr       = '0;
    bus.dstore      = '0;
    bus.fill_wen    = 1'b0;
    bus.fill_offset = 1'b0;
    bus.fill_data   = bus.dload;
    bus.line_commit = 1'b0;
    bus.fill_tag    = tag_q;
    bus.line_clean  = 1'b0;
    bus.busy        = (state_q != IDLE);
    bus.flushed     = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        cur_idx = bus.req_addr[IDX_W+2:3];
        cur_way = bus.victim_way;
      end
      FL_CHK, FL_WB0, FL_WB1, FL_NEXT, DONE: begin
        cur_idx = cnt_q[CNT_W-1:1];
        cur_way = cnt_q[0];
      end
      default: ;
    endcase

    off        = (state_q == WB1) || (state_q == FILL1) || (state_q == FL_WB1);
    bus.rd_idx = cur_idx;
    bus.rd_way = cur_way;

    unique case (state_q)
      WB0, WB1, FL_WB0, FL_WB1: begin
        bus.dWEN       = 1'b1;
        bus.daddr      = {bus.rd_tag, cur_idx, off, 2'b00};
        bus.dstore     = off ? bus.rd_data1 : bus.rd_data0;
        bus.line_clean = (state_q == FL_WB1) && !bus.dwait;
      end
      FILL0, FILL1: begin
        bus.dREN        = 1'b1;
        bus.daddr       = {tag_q, cur_idx, off, 2'b00};
        bus.fill_wen    = !bus.dwait;
        bus.fill_offset = off;
        bus.line_commit = (state_q == FILL1) && !bus.dwait;
      end
      default: ;
    endcase

    // Outputs follow reset immediately, not just once the state register clears.
    if (!nRST) begin
      bus.rd_idx      = '0;
      bus.rd_way      = 1'b0;
      bus.dREN        = 1'b0;
      bus.dWEN        = 1'b0;
      bus.daddr       = '0;
      bus.dstore      = '0;
      bus.fill_wen    = 1'b0;
      bus.fill_offset = 1'b0;
      bus.fill_data   = '0;
      bus.line_commit = 1'b0;
      bus.fill_tag    = '0;
      bus.line_clean  = 1'b0;
      bus.busy        = 1'b0;
      bus.flushed     = 1'b0;
    end
  end

endmodule
